osd_char_overlay: RTL and testbench

- Character-OSD overlay stage for the HDMI character display path. Sits directly upstream of the osd_rom font/bitmap ROM: it drives the ROM address and consumes its byte output.
- It tracks pixel position from the incoming video timing, fetches the 1-bpp bitmap byte for the OSD window, and selects the pixel bit.
- It replaces foreground pixels with a fixed colour and forwards timing plus pixels to the HDMI encoder with a fixed latency.

---
 rtl/osd_char_overlay_if.sv | 29 ++
 rtl/osd_char_overlay.sv | 149 ++++++++++++++
 tb/tb_osd_char_overlay.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/osd_char_overlay_if.sv
// Video-in / video-out / font-ROM signal bundle for osd_char_overlay.
// slave = overlay stage, master = video source + ROM + sink side.
interface osd_char_overlay_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  // Streaming video with no backpressure: de_in qualifies a pixel on every
  // clock it is high and the sink always accepts; there is no valid/ready pair.
  logic                  hs_in;
  logic                  vs_in;
  logic                  de_in;
  logic [23:0]           rgb_in;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  hs_out;
  logic                  vs_out;
  logic                  de_out;
  logic [23:0]           rgb_out;

  modport slave (
    input  hs_in, vs_in, de_in, rgb_in, rom_data,
    output rom_addr, hs_out, vs_out, de_out, rgb_out
  );

  modport master (
    output hs_in, vs_in, de_in, rgb_in, rom_data,
    input  rom_addr, hs_out, vs_out, de_out, rgb_out
  );
endinterface

// File: rtl/osd_char_overlay.sv
// Character-OSD overlay: fetches 1-bpp bitmap bytes from osd_rom and paints FG_COLOR, 3-cycle latency.
// Define OSD_CHAR_OVERLAY_BG_EN to fill window '0' pixels with BG_COLOR (opaque box).
module osd_char_overlay #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 8,
  parameter int          OSD_X      = 9,
  parameter int          OSD_Y      = 9,
  parameter int          OSD_W      = 256,
  parameter int          OSD_H      = 64,
  parameter bit          VS_POL     = 1'b1,
  parameter logic [23:0] FG_COLOR   = 24'hFF0000,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input logic clk,
  input logic rst,
  osd_char_overlay_if.slave bus
);

  localparam int CW    = 16;
  localparam int SHIFT = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] X_LO = CW'(OSD_X);
  localparam logic [CW-1:0] X_HI = CW'(OSD_X + OSD_W);
  localparam logic [CW-1:0] Y_LO = CW'(OSD_Y);
  localparam logic [CW-1:0] Y_HI = CW'(OSD_Y + OSD_H);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(OSD_W / DATA_WIDTH);
`ifdef OSD_CHAR_OVERLAY_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif

  // Stage 0: position tracking
  logic [CW-1:0]         x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, x_off;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  de_prev_q, vs_prev_q;
  logic                  frame_ok_q, frame_ok_d;
  logic                  line_win_q, line_win_d;
  logic                  de_fall, vs_edge, win;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [SHIFT-1:0]      bit_d;

  // Stage 1 / 2 pipeline
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  win_d1_q, de_d1_q, hs_d1_q, vs_d1_q;
  logic                  win_d2_q, de_d2_q, hs_d2_q, vs_d2_q;
  logic [SHIFT-1:0]      bit_d1_q, bit_d2_q;
  logic [23:0]           rgb_d1_q, rgb_d2_q;
  logic                  sel_bit;

  // Stage 3 outputs
  logic                  hs_out_q, vs_out_q, de_out_q;
  logic [23:0]           rgb_out_q, rgb_out_d;

  always_comb begin
    de_fall    = de_prev_q & ~bus.de_in;
    vs_edge    = (bus.vs_in == VS_POL) & (vs_prev_q != VS_POL);
    x_off      = x_cnt_q - X_LO;
    win        = bus.de_in & frame_ok_q & (x_cnt_q >= X_LO) & (x_cnt_q < X_HI)
               & (y_cnt_q >= Y_LO) & (y_cnt_q < Y_HI);
    addr_d     = win ? (row_base_q + ADDR_WIDTH'(x_off >> SHIFT)) : '0;
    bit_d      = x_off[SHIFT-1:0];
    x_cnt_d    = bus.de_in ? (x_cnt_q + CW'(1)) : '0;
    y_cnt_d    = y_cnt_q;
    row_base_d = row_base_q;
    line_win_d = line_win_q | win;
    frame_ok_d = frame_ok_q | vs_edge;
    // A vsync edge landing on the same cycle as a de fall must win.
    if (vs_edge) begin
      y_cnt_d    = '0;
      row_base_d = '0;
      line_win_d = 1'b0;
    end else if (de_fall) begin
      y_cnt_d    = y_cnt_q + CW'(1);
      line_win_d = 1'b0;
      if (line_win_q) row_base_d = row_base_q + ROW_STEP;
    end
  end

  // MSB-first: pixel offset 0 takes rom_data[DATA_WIDTH-1]; ~idx == DATA_WIDTH-1-idx.
  always_comb begin
    sel_bit   = bus.rom_data[~bit_d2_q];
    rgb_out_d = rgb_d2_q;
    if (!de_d2_q)                rgb_out_d = '0;
    else if (win_d2_q & sel_bit) rgb_out_d = FG_COLOR;
    else if (win_d2_q & BG_EN)   rgb_out_d = BG_COLOR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      row_base_q <= '0;
      de_prev_q  <= 1'b0;
      // Start "already in vsync" so only a genuine transition enables the overlay.
      vs_prev_q  <= VS_POL;
      frame_ok_q <= 1'b0;
      line_win_q <= 1'b0;
      rom_addr_q <= '0;
      win_d1_q   <= 1'b0;
      de_d1_q    <= 1'b0;
      hs_d1_q    <= 1'b0;
      vs_d1_q    <= 1'b0;
      bit_d1_q   <= '0;
      rgb_d1_q   <= '0;
      win_d2_q   <= 1'b0;
      de_d2_q    <= 1'b0;
      hs_d2_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      bit_d2_q   <= '0;
      rgb_d2_q   <= '0;
      hs_out_q   <= 1'b0;
      vs_out_q   <= 1'b0;
      de_out_q   <= 1'b0;
      rgb_out_q  <= '0;
    end else begin
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      row_base_q <= row_base_d;
      de_prev_q  <= bus.de_in;
      vs_prev_q  <= bus.vs_in;
      frame_ok_q <= frame_ok_d;
      line_win_q <= line_win_d;
      rom_addr_q <= addr_d;
      win_d1_q   <= win;
      de_d1_q    <= bus.de_in;
      hs_d1_q    <= bus.hs_in;
      vs_d1_q    <= bus.vs_in;
      bit_d1_q   <= bit_d;
      rgb_d1_q   <= bus.rgb_in;
      win_d2_q   <= win_d1_q;
      de_d2_q    <= de_d1_q;
      hs_d2_q    <= hs_d1_q;
      vs_d2_q    <= vs_d1_q;
      bit_d2_q   <= bit_d1_q;
      rgb_d2_q   <= rgb_d1_q;
      hs_out_q   <= hs_d2_q;
      vs_out_q   <= vs_d2_q;
      de_out_q   <= de_d2_q;
      rgb_out_q  <= rgb_out_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.hs_out   = hs_out_q;
  assign bus.vs_out   = vs_out_q;
  assign bus.de_out   = de_out_q;
  assign bus.rgb_out  = rgb_out_q;

endmodule

// File: tb/tb_osd_char_overlay.sv
// Randomized bench for osd_char_overlay against a coordinate-level reference model.
// Honours OSD_CHAR_OVERLAY_BG_EN in the same way as the design.
module tb_osd_char_overlay;
  localparam int          AW     = 11;
  localparam int          DW     = 8;
  localparam int          OSD_X  = 9;
  localparam int          OSD_Y  = 9;
  localparam int          OSD_W  = 256;
  localparam int          OSD_H  = 64;
  localparam bit          VS_POL = 1'b1;
  localparam logic [23:0] FG     = 24'hFF0000;
  localparam logic [23:0] BG     = 24'h0000FF;
  localparam logic [23:0] GRN    = 24'h00FF00;
  localparam int          HACT   = 270;
  localparam int          HBLANK = 6;
  localparam int          NLINES = 75;
  localparam int          VS_LEN = 4;
`ifdef OSD_CHAR_OVERLAY_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic        lit_v;
    logic [23:0] lit_rgb;
  } exp_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  osd_char_overlay_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  osd_char_overlay #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OSD_X(OSD_X), .OSD_Y(OSD_Y),
    .OSD_W(OSD_W), .OSD_H(OSD_H), .VS_POL(VS_POL), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Font ROM: synchronous read, data one cycle after the address
  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  // Scoreboard
  exp_t          exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            lit_addr_q[$];
  int            checks   = 0;
  int            failures = 0;
  bit            m_frame_ok;
  logic          m_vs_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 20) $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int lit_addr(input int x, input int y);
    if (y == 9  && x >= 9   && x <= 16)  return 0;
    if (y == 9  && x == 17)              return 1;
    if (y == 9  && x >= 257 && x <= 264) return 31;
    if (y == 10 && x == 9)               return 32;
    if (y == 72 && x >= 257 && x <= 264) return 2047;
    if (y == 72 && x == 265)             return 0;
    if (y == 73 && x == 9)               return 0;
    return -1;
  endfunction

  // Expected pixels on line 9, x=8..17, for rgb_in=00FF00 and byte 0 = A5
  function automatic logic [23:0] lit_pat(input int x);
    case (x)
      8:              return GRN;
      9, 11, 14, 16:  return FG;
      default:        return BG_EN ? BG : GRN;
    endcase
  endfunction

  // Driver: check what left the pipe, then apply one input cycle and predict it
  task automatic step(input logic hs, input logic vs, input logic de, input logic [23:0] rgb,
                      input int x, input int y, input bit lit_en);
    exp_t o, e;
    bit   w, b;
    int   a;
    @(negedge clk);
    o = exp_q.pop_front();
    check("hs_out",  bus.hs_out,  o.hs);
    check("vs_out",  bus.vs_out,  o.vs);
    check("de_out",  bus.de_out,  o.de);
    check("rgb_out", bus.rgb_out, o.rgb);
    if (o.lit_v) check("rgb_pattern", bus.rgb_out, o.lit_rgb);
    check("rom_addr", bus.rom_addr, exp_addr_q.pop_front());
    a = lit_addr_q.pop_front();
    if (a >= 0) check("rom_addr_pt", bus.rom_addr, a);

    bus.hs_in  = hs;
    bus.vs_in  = vs;
    bus.de_in  = de;
    bus.rgb_in = rgb;

    w = de && m_frame_ok && x >= OSD_X && x < OSD_X + OSD_W && y >= OSD_Y && y < OSD_Y + OSD_H;
    a = w ? (y - OSD_Y) * (OSD_W / DW) + (x - OSD_X) / DW : 0;
    b = w ? rom_mem[a][DW - 1 - ((x - OSD_X) % DW)] : 1'b0;
    e.hs      = hs;
    e.vs      = vs;
    e.de      = de;
    e.rgb     = !de ? 24'h0 : (w && b) ? FG : (w && BG_EN) ? BG : rgb;
    e.lit_v   = lit_en && m_frame_ok && de && y == 9 && x >= 8 && x <= 17;
    e.lit_rgb = e.lit_v ? lit_pat(x) : 24'h0;
    exp_q.push_back(e);
    exp_addr_q.push_back(AW'(a));
    lit_addr_q.push_back((m_frame_ok && de) ? lit_addr(x, y) : -1);

    if (vs == VS_POL && m_vs_prev != VS_POL) m_frame_ok = 1'b1;
    m_vs_prev = vs;
  endtask

  // Release reset on a negedge with idle inputs; pipeline starts empty
  task automatic release_reset();
    exp_t z, idle;
    @(negedge clk);
    bus.hs_in  = 1'b0;
    bus.vs_in  = ~VS_POL;
    bus.de_in  = 1'b0;
    bus.rgb_in = 24'h0;
    rst        = 1'b0;
    m_frame_ok = 1'b0;
    m_vs_prev  = ~VS_POL;
    z          = '0;
    idle       = '0;
    idle.vs    = ~VS_POL;
    exp_q.delete();
    exp_addr_q.delete();
    lit_addr_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
    exp_q.push_back(idle);
    exp_addr_q.push_back('0);
    lit_addr_q.push_back(-1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_hs"},   bus.hs_out,   0);
    check({tag, "_vs"},   bus.vs_out,   0);
    check({tag, "_de"},   bus.de_out,   0);
    check({tag, "_rgb"},  bus.rgb_out,  0);
    check({tag, "_addr"}, bus.rom_addr, 0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic frame(input int nlines, input bit const_rgb, input int rst_line);
    repeat (VS_LEN) step(1'b0, VS_POL, 1'b0, 24'($urandom), -1, -1, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      for (int h = 0; h < HBLANK; h++)
        step(h < 2, ~VS_POL, 1'b0, 24'($urandom), -1, -1, 1'b0);
      for (int p = 0; p < HACT; p++) begin
        step(1'b0, ~VS_POL, 1'b1, const_rgb ? GRN : 24'($urandom), p, l, const_rgb);
        if (l == rst_line && p == 100) mid_reset();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'($urandom);
    rom_mem[0]    = 8'hA5;
    rom_mem[1][7] = 1'b0;

    rst        = 1'b1;
    bus.hs_in  = 1'b0;
    bus.vs_in  = ~VS_POL;
    bus.de_in  = 1'b0;
    bus.rgb_in = 24'h0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    release_reset();

    // Random de pulse train before any vsync: pure delayed pass-through
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 6)) step(1'($urandom), ~VS_POL, 1'b0, 24'($urandom), -1, -1, 1'b0);
      for (int p = 0; p < int'($urandom_range(1, 30)); p++)
        step(1'($urandom), ~VS_POL, 1'b1, 24'($urandom), p + OSD_X, i + OSD_Y, 1'b0);
    end

    frame(NLINES, 1'b1, -1);   // pattern + full addressing sweep
    frame(NLINES, 1'b0, -1);   // second frame, vsync on the de fall, random pixels
    frame(40, 1'b0, 30);       // reset at line 30; overlay off until next vsync
    frame(12, 1'b1, -1);       // overlay resumes after the vsync

    repeat (4) step(1'b0, ~VS_POL, 1'b0, 24'h0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
